// File: rtl/alu_share_arbiter_if.sv
// Request/ALU/response bundle between the lanes, the shared ALU and the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface alu_share_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [8*NUM_REQ-1:0] req_rs;
    logic [8*NUM_REQ-1:0] req_rt;
    logic [2*NUM_REQ-1:0] req_op;
    logic [7:0]           alu_rs;
    logic [7:0]           alu_rt;
    logic [1:0]           alu_op;
    logic [7:0]           alu_out;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IdW-1:0]       rsp_id;
    logic [7:0]           rsp_data;
    logic                 rsp_dz;

    modport slave (
        input  req_valid, req_rs, req_rt, req_op, alu_out, rsp_ready,
        output req_ready, alu_rs, alu_rt, alu_op, rsp_valid, rsp_id, rsp_data, rsp_dz
    );

    modport master (
        output req_valid, req_rs, req_rt, req_op, alu_out, rsp_ready,
        input  req_ready, alu_rs, alu_rt, alu_op, rsp_valid, rsp_id, rsp_data, rsp_dz
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU among NUM_REQ lanes; one operation
// in flight, fixed per-opcode latency, result held until the response handshake.
module alu_share_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned LAT_ADDSUB = 1,
    parameter int unsigned LAT_MUL    = 2,
    parameter int unsigned LAT_DIV    = 4
) (
    input logic                clk,
    input logic                reset,
    alu_share_arbiter_if.slave bus
);
    localparam int unsigned IdW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned MaxLat0 = (LAT_ADDSUB > LAT_MUL) ? LAT_ADDSUB : LAT_MUL;
    localparam int unsigned MaxLat  = (MaxLat0 > LAT_DIV) ? MaxLat0 : LAT_DIV;
    localparam int unsigned CntW    = (MaxLat > 1) ? $clog2(MaxLat) : 1;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e          state_q, state_d;
    logic [IdW-1:0]  ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      alu_rs_q, alu_rs_d, alu_rt_q, alu_rt_d;
    logic [1:0]      alu_op_q, alu_op_d;
    logic [IdW-1:0]  rsp_id_q, rsp_id_d;
    logic [7:0]      rsp_data_q, rsp_data_d;
    logic            rsp_dz_q, rsp_dz_d;

    logic            found;
    logic [IdW-1:0]  win;
    int unsigned     idx;
    logic [1:0]      win_op;
    logic [CntW-1:0] lat_m1;
    logic            div_zero;

    // First valid lane at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(ptr_q) + i) % NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = IdW'(idx);
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (state_q == StIdle && found) begin
            bus.req_ready[win] = 1'b1;
        end
    end

    assign win_op   = bus.req_op[{win, 1'b0} +: 2];
    assign div_zero = (alu_op_q == 2'b11) && (alu_rt_q == 8'd0);

    always_comb begin
        unique case (win_op)
            2'b00, 2'b01: lat_m1 = CntW'(LAT_ADDSUB - 1);
            2'b10:        lat_m1 = CntW'(LAT_MUL - 1);
            default:      lat_m1 = CntW'(LAT_DIV - 1);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        alu_rs_d   = alu_rs_q;
        alu_rt_d   = alu_rt_q;
        alu_op_d   = alu_op_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_dz_d   = rsp_dz_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    alu_rs_d = bus.req_rs[{win, 3'b000} +: 8];
                    alu_rt_d = bus.req_rt[{win, 3'b000} +: 8];
                    alu_op_d = win_op;
                    rsp_id_d = win;
                    cnt_d    = lat_m1;
                    ptr_d    = (win == IdW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                    state_d  = StExec;
                end
            end
            StExec: begin
                if (cnt_q == '0) begin
                    // Divide-by-zero is flagged here; the ALU's own value is ignored.
                    rsp_dz_d   = div_zero;
                    rsp_data_d = div_zero ? 8'hFF : bus.alu_out;
                    state_d    = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            cnt_q      <= '0;
            alu_rs_q   <= '0;
            alu_rt_q   <= '0;
            alu_op_q   <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
            rsp_dz_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            alu_rs_q   <= alu_rs_d;
            alu_rt_q   <= alu_rt_d;
            alu_op_q   <= alu_op_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_dz_q   <= rsp_dz_d;
        end
    end

    assign bus.alu_rs    = alu_rs_q;
    assign bus.alu_rt    = alu_rt_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_dz    = rsp_dz_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: expected responses are queued at each
// grant and compared when the arbiter presents them.
module tb_alu_share_arbiter;
    localparam int unsigned N = 4;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       dz;
        logic [7:0] rs;
        logic [7:0] rt;
        logic [1:0] op;
    } exp_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    alu_share_arbiter_if #(.NUM_REQ(N)) bus ();

    alu_share_arbiter #(
        .NUM_REQ   (N),
        .LAT_ADDSUB(1),
        .LAT_MUL   (2),
        .LAT_DIV   (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; its divide-by-zero value is deliberately not 8'hFF.
    always_comb begin
        case (bus.alu_op)
            2'b00:   bus.alu_out = bus.alu_rs + bus.alu_rt;
            2'b01:   bus.alu_out = bus.alu_rs - bus.alu_rt;
            2'b10:   bus.alu_out = bus.alu_rs * bus.alu_rt;
            default: bus.alu_out = (bus.alu_rt == 8'd0) ? 8'h5A : bus.alu_rs / bus.alu_rt;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input logic [1:0] op);
        if (!op[1])       return 1;
        else if (!op[0])  return 2;
        else              return 4;
    endfunction

    function automatic exp_t model(input int lane, input logic [1:0] op,
                                   input logic [7:0] a, input logic [7:0] b);
        exp_t        e;
        logic [15:0] p;
        e    = '0;
        e.id = 2'(lane);
        e.rs = a;
        e.rt = b;
        e.op = op;
        p    = 16'(a) * 16'(b);
        case (op)
            2'b00:   e.data = 8'(16'(a) + 16'(b));
            2'b01:   e.data = 8'(16'(a) - 16'(b));
            2'b10:   e.data = p[7:0];
            default: begin
                if (b == 8'd0) begin
                    e.data = 8'hFF;
                    e.dz   = 1'b1;
                end else begin
                    e.data = a / b;
                end
            end
        endcase
        return e;
    endfunction

    task automatic set_lane(input int lane, input logic [1:0] op,
                            input logic [7:0] a, input logic [7:0] b);
        bus.req_rs[8*lane +: 8] = a;
        bus.req_rt[8*lane +: 8] = b;
        bus.req_op[2*lane +: 2] = op;
        bus.req_valid[lane]     = 1'b1;
    endtask

    task automatic chk_rst_outs(input string tag);
        chk(tag, 32'({bus.alu_rs, bus.alu_rt, bus.alu_op, bus.rsp_valid,
                      bus.rsp_id, bus.rsp_data, bus.rsp_dz}), 32'd0);
    endtask

    // Expects lane to win the current IDLE cycle; queues its result, takes the edge.
    task automatic accept(input int lane, input bit keep);
        exp_t e;
        #1;
        chk("grant", 32'(bus.req_ready), 32'(1) << lane);
        e = model(lane, bus.req_op[2*lane +: 2], bus.req_rs[8*lane +: 8],
                  bus.req_rt[8*lane +: 8]);
        sb.push_back(e);
        tick();
        if (!keep) bus.req_valid[lane] = 1'b0;
        chk("alu_latch", 32'({bus.alu_op, bus.alu_rs, bus.alu_rt}), 32'({e.op, e.rs, e.rt}));
    endtask

    // Called just after the acceptance edge; holds the response for 'hold' cycles.
    task automatic wait_rsp(input int lat, input int hold);
        exp_t e;
        int   n   = 0;
        bit   got = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            tick();
            if (bus.rsp_valid) begin
                got = 1;
                n   = k;
            end
        end
        chk("rsp_latency", 32'(n), 32'(lat));
        e = '0;
        if (sb.size() != 0) e = sb.pop_front();
        if (got) begin
            chk("rsp_fields", 32'({bus.rsp_id, bus.rsp_data, bus.rsp_dz}),
                32'({e.id, e.data, e.dz}));
            chk("alu_stable", 32'({bus.alu_op, bus.alu_rs, bus.alu_rt}),
                32'({e.op, e.rs, e.rt}));
            for (int h = 0; h < hold; h++) begin
                tick();
                chk("hold_fields", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_dz}),
                    32'({1'b1, e.id, e.data, e.dz}));
                chk("hold_no_grant", 32'(bus.req_ready), 32'd0);
            end
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("handshake_no_grant", 32'(bus.req_ready), 32'd0);
        tick();
        chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        reset         = 1'b0;
        bus.req_valid = '0;
        bus.req_rs    = '0;
        bus.req_rt    = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b1;
        tick();
        tick();
        chk_rst_outs("reset_state");
        chk("reset_no_grant", 32'(bus.req_ready), 32'd0);
        reset = 1'b1;
        tick();

        // Single operations, including wraparound and divide-by-zero.
        set_lane(2, 2'b00, 8'd100, 8'd27);
        accept(2, 0);
        wait_rsp(1, 0);
        set_lane(0, 2'b01, 8'd5, 8'd9);
        accept(0, 0);
        wait_rsp(1, 0);
        set_lane(1, 2'b11, 8'd200, 8'd0);
        accept(1, 0);
        wait_rsp(4, 0);
        set_lane(2, 2'b11, 8'd200, 8'd7);
        accept(2, 0);
        wait_rsp(4, 0);

        // After reset all lanes request MUL continuously: order 0,1,2,3,0.
        reset = 1'b0;
        tick();
        chk_rst_outs("reset_pulse");
        reset = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) set_lane(i, 2'b10, 8'(3 + i), 8'(50 + 20 * i));
        for (int k = 0; k < 5; k++) begin
            accept(k % 4, 1);
            wait_rsp(2, 0);
        end
        bus.req_valid = '0;

        // Stalled response with lane 3 pending; pointer is at 1.
        set_lane(1, 2'b00, 8'd10, 8'd20);
        set_lane(3, 2'b01, 8'd7, 8'd3);
        bus.rsp_ready = 1'b0;
        accept(1, 0);
        wait_rsp(1, 10);
        accept(3, 0);
        wait_rsp(1, 0);

        // Reset mid-DIV aborts the operation.
        set_lane(1, 2'b11, 8'd50, 8'd5);
        accept(1, 0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk_rst_outs("reset_in_exec");
        sb.delete();
        tick();
        tick();
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("no_rsp_after_abort", 32'(bus.rsp_valid), 32'd0);
        end
        set_lane(3, 2'b00, 8'd1, 8'd2);
        set_lane(2, 2'b00, 8'd250, 8'd10);
        accept(2, 0);
        wait_rsp(1, 0);
        accept(3, 0);
        wait_rsp(1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
